reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter REG_BIT_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter NUM_OF_REGS, default 32, number of architectural registers.
REQ-003 SHALL have parameter REG_ENCODE_WIDTH, default $clog2(NUM_OF_REGS), register address width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-006 SHALL have ports alu_valid in 1, alu_ready out 1, alu_addr in REG_ENCODE_WIDTH, alu_data in REG_BIT_WIDTH: the ALU writeback request channel.
REQ-007 SHALL have ports mem_valid in 1, mem_ready out 1, mem_addr in REG_ENCODE_WIDTH, mem_data in REG_BIT_WIDTH: the load-unit writeback request channel.
REQ-008 SHALL have port hold, input, 1 bit, pipeline freeze: no grants while high.
REQ-009 SHALL have ports rd_wr_en out 1, rd_addr out REG_ENCODE_WIDTH, rd_data out REG_BIT_WIDTH, driving the register file's single write port.
REQ-010 SHALL have port last_grant_mem, output, 1 bit, arbiter state (1 = mem won the most recent conflict-free or contested grant).

Function
REQ-011 A transfer on a channel SHALL occur in the cycle where valid and ready are both high.
REQ-012 ready SHALL be combinational from valid, hold, rst and arbiter state only, never from data or addr.
REQ-013 Exactly one channel may be granted per cycle; both ready low while hold or rst is high.
REQ-014 Only one channel valid, hold low: that channel's ready SHALL be high.
REQ-015 Both valid, hold low: grant SHALL go to the channel not granted last (round-robin); state PREFER_ALU grants alu, PREFER_MEM grants mem.
REQ-016 Arbiter state SHALL move to PREFER_MEM after an alu grant and to PREFER_ALU after a mem grant; no grant leaves it unchanged.
REQ-017 A requester not granted SHALL hold valid, addr, data stable until granted; the block SHALL not require this to be checked.
REQ-018 Latency SHALL be exactly one cycle: a transfer in cycle N drives rd_wr_en=1, rd_addr, rd_data in cycle N+1 from the output register.
REQ-019 A granted transfer with addr 0 SHALL be accepted (ready high) but drive rd_wr_en=0 in cycle N+1 (x0 write dropped).
REQ-020 Cycle with no transfer SHALL drive rd_wr_en=0 in the next cycle; rd_addr/rd_data SHALL retain last values.
REQ-021 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-022 hold rising while the output register holds a write SHALL still deliver that write in the following cycle (hold blocks acceptance, not retirement).
REQ-023 Same destination from both channels in consecutive grants SHALL be written in grant order; later value persists.

Reset
REQ-024 While rst is high at a clock edge: rd_wr_en=0, rd_addr=0, rd_data=0, state=PREFER_ALU, last_grant_mem=0.
REQ-025 rst mid-operation SHALL discard any write in the output register; no rd_wr_en pulse after the reset edge.
REQ-026 First cycle after rst deasserts SHALL permit grants normally.

Structure
REQ-027 Shared package SHALL hold the arb_state_t enum (PREFER_ALU, PREFER_MEM) and the wb_req_t struct (valid, addr, data).
REQ-028 A sub-module rr_arb2 (two-way round-robin arbiter with hold, synchronous reset) SHALL own the state and grant logic; the top holds the output register and x0 filtering.
REQ-029 No asynchronous-reset flops SHALL be used in this block.

Verification
REQ-030 Reset then alu_valid=1 alu_addr=5 alu_data=0xDEADBEEF alone -> alu_ready=1 same cycle; next cycle rd_wr_en=1 rd_addr=5 rd_data=0xDEADBEEF.
REQ-031 Both valid for 4 cycles after reset (alu addr 1, mem addr 2) -> grants alu, mem, alu, mem; rd_addr 1,2,1,2 on the following cycles.
REQ-032 mem_valid=1 mem_addr=0 mem_data=0x1234 -> mem_ready=1; next cycle rd_wr_en=0.
REQ-033 hold=1 with both valid for 3 cycles -> both ready=0, rd_wr_en=0 after the first cycle; hold=0 -> alu granted (state unchanged).
REQ-034 alu transfer to addr 7 then rst=1 next cycle -> rd_wr_en=0 in all cycles from the reset edge; post-reset state PREFER_ALU.
REQ-035 Continuous alu-only stream of 8 writes (addrs 1..8) -> 8 consecutive cycles of rd_wr_en=1, addrs 1..8 in order.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_arbiter_pkg
// Description : Shared types for the register-file writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_wb_arbiter_pkg;

   // Upper bounds for the instance widths carried inside wb_req_t.
   localparam int c_MAX_DATA_WIDTH = 64;
   localparam int c_MAX_ADDR_WIDTH = 8;

   typedef enum logic [0:0] {
      PREFER_ALU = 1'b0,
      PREFER_MEM = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                        valid;
      logic [c_MAX_ADDR_WIDTH-1:0] addr;
      logic [c_MAX_DATA_WIDTH-1:0] data;
   } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/reg_wb_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with freeze input.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
   import reg_wb_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic hold,
   input  logic alu_valid,
   input  logic mem_valid,
   output logic alu_grant,
   output logic mem_grant,
   output logic last_grant_mem
);

   arb_state_t r_state;
   logic       r_last_grant_mem;
   logic       w_open;

   // Grants depend only on request valids, freeze, reset and arbiter state.
   assign w_open    = !rst && !hold;
   assign alu_grant = w_open && alu_valid && (!mem_valid || (r_state == PREFER_ALU));
   assign mem_grant = w_open && mem_valid && (!alu_valid || (r_state == PREFER_MEM));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= PREFER_ALU;
         r_last_grant_mem <= 1'b0;
      end else if (alu_grant) begin
         r_state          <= PREFER_MEM;
         r_last_grant_mem <= 1'b0;
      end else if (mem_grant) begin
         r_state          <= PREFER_ALU;
         r_last_grant_mem <= 1'b1;
      end
   end

   assign last_grant_mem = r_last_grant_mem;

endmodule
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_arbiter
// Description : Arbitrates ALU and load writebacks onto one register-file port.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_arbiter
   import reg_wb_arbiter_pkg::*;
#(
   parameter int REG_BIT_WIDTH    = 32,
   parameter int NUM_OF_REGS      = 32,
   parameter int REG_ENCODE_WIDTH = $clog2(NUM_OF_REGS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alu_valid,
   output logic                        alu_ready,
   input  logic [REG_ENCODE_WIDTH-1:0] alu_addr,
   input  logic [REG_BIT_WIDTH-1:0]    alu_data,
   input  logic                        mem_valid,
   output logic                        mem_ready,
   input  logic [REG_ENCODE_WIDTH-1:0] mem_addr,
   input  logic [REG_BIT_WIDTH-1:0]    mem_data,
   input  logic                        hold,
   output logic                        rd_wr_en,
   output logic [REG_ENCODE_WIDTH-1:0] rd_addr,
   output logic [REG_BIT_WIDTH-1:0]    rd_data,
   output logic                        last_grant_mem
);

   wb_req_t                     w_alu_req;
   wb_req_t                     w_mem_req;
   wb_req_t                     w_sel_req;
   logic                        w_alu_grant;
   logic                        w_mem_grant;
   logic                        w_xfer;
   logic [REG_ENCODE_WIDTH-1:0] w_sel_addr;
   logic [REG_BIT_WIDTH-1:0]    w_sel_data;
   logic                        w_unused_bits;

   logic                        r_rd_wr_en;
   logic [REG_ENCODE_WIDTH-1:0] r_rd_addr;
   logic [REG_BIT_WIDTH-1:0]    r_rd_data;

   always_comb begin
      w_alu_req       = '0;
      w_alu_req.valid = alu_valid;
      w_alu_req.addr[REG_ENCODE_WIDTH-1:0] = alu_addr;
      w_alu_req.data[REG_BIT_WIDTH-1:0]    = alu_data;
      w_mem_req       = '0;
      w_mem_req.valid = mem_valid;
      w_mem_req.addr[REG_ENCODE_WIDTH-1:0] = mem_addr;
      w_mem_req.data[REG_BIT_WIDTH-1:0]    = mem_data;
   end

   rr_arb2 u_arb (
      .clk            (clk),
      .rst            (rst),
      .hold           (hold),
      .alu_valid      (alu_valid),
      .mem_valid      (mem_valid),
      .alu_grant      (w_alu_grant),
      .mem_grant      (w_mem_grant),
      .last_grant_mem (last_grant_mem)
   );

   assign alu_ready = w_alu_grant;
   assign mem_ready = w_mem_grant;
   assign w_xfer    = w_alu_grant || w_mem_grant;

   assign w_sel_req  = w_mem_grant ? w_mem_req : w_alu_req;
   assign w_sel_addr = w_sel_req.addr[REG_ENCODE_WIDTH-1:0];
   assign w_sel_data = w_sel_req.data[REG_BIT_WIDTH-1:0];
   assign w_unused_bits = ^w_sel_req;

   // Writes to x0 are accepted upstream but never reach the register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_wr_en <= 1'b0;
         r_rd_addr  <= '0;
         r_rd_data  <= '0;
      end else begin
         r_rd_wr_en <= w_xfer && (w_sel_addr != '0);
         if (w_xfer) begin
            r_rd_addr <= w_sel_addr;
            r_rd_data <= w_sel_data;
         end
      end
   end

   assign rd_wr_en = r_rd_wr_en;
   assign rd_addr  = r_rd_addr;
   assign rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_arbiter
// Description : Directed self-checking bench for reg_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        mem_valid, mem_ready;
   logic [4:0]  mem_addr;
   logic [31:0] mem_data;
   logic        hold;
   logic        rd_wr_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        last_grant_mem;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_wb_arbiter #(
      .REG_BIT_WIDTH (32),
      .NUM_OF_REGS   (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_addr       (alu_addr),
      .alu_data       (alu_data),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .hold           (hold),
      .rd_wr_en       (rd_wr_en),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .last_grant_mem (last_grant_mem)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd9;  alu_data = 32'h99;
      mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'hAA;
      tick(); tick();
      check("rst_alu_ready", alu_ready, 0);
      check("rst_mem_ready", mem_ready, 0);
      check("rst_wr_en", rd_wr_en, 0);
      check("rst_addr", rd_addr, 0);
      check("rst_data", rd_data, 0);
      check("rst_last_mem", last_grant_mem, 0);

      // Single ALU write
      rst = 1'b0; mem_valid = 1'b0;
      alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
      settle();
      check("single_alu_ready", alu_ready, 1);
      check("single_mem_ready", mem_ready, 0);
      tick();
      alu_valid = 1'b0;
      check("single_wr_en", rd_wr_en, 1);
      check("single_addr", rd_addr, 5);
      check("single_data", rd_data, 32'hDEADBEEF);
      tick();
      check("idle_wr_en", rd_wr_en, 0);
      check("idle_addr_kept", rd_addr, 5);
      check("idle_data_kept", rd_data, 32'hDEADBEEF);

      // Contention from a fresh reset: alternating grants
      rst = 1'b1; tick(); rst = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
      mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("rr_alu_ready", alu_ready, (i % 2 == 0));
         check("rr_mem_ready", mem_ready, (i % 2 == 1));
         tick();
         check("rr_wr_en", rd_wr_en, 1);
         check("rr_addr", rd_addr, (i % 2 == 0) ? 1 : 2);
         check("rr_data", rd_data, (i % 2 == 0) ? 32'h11 : 32'h22);
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      check("rr_last_mem", last_grant_mem, 1);

      // x0 write from the load channel is accepted but dropped
      mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h1234;
      settle();
      check("x0_mem_ready", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      check("x0_wr_en", rd_wr_en, 0);

      // Load write in flight, then freeze with both channels requesting
      mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
      tick();
      hold = 1'b1;
      alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
      mem_addr = 5'd6; mem_data = 32'h66;
      settle();
      check("hold_alu_ready", alu_ready, 0);
      check("hold_mem_ready", mem_ready, 0);
      check("hold_retire_wr_en", rd_wr_en, 1);
      check("hold_retire_addr", rd_addr, 3);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_wr_en", rd_wr_en, 0);
         check("hold_alu_ready_n", alu_ready, 0);
         check("hold_mem_ready_n", mem_ready, 0);
      end
      hold = 1'b0;
      settle();
      check("unhold_alu_ready", alu_ready, 1);
      check("unhold_mem_ready", mem_ready, 0);
      tick();
      check("unhold_addr", rd_addr, 4);
      check("unhold_data", rd_data, 32'h44);
      alu_valid = 1'b0;
      settle();
      check("unhold_mem_next", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      check("unhold_mem_addr", rd_addr, 6);
      check("unhold_mem_wr_en", rd_wr_en, 1);

      // Reset discards a write already in the output register
      alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
      tick();
      alu_valid = 1'b0; rst = 1'b1;
      check("pre_rst_wr_en", rd_wr_en, 1);
      tick();
      check("mid_rst_wr_en", rd_wr_en, 0);
      check("mid_rst_addr", rd_addr, 0);
      check("mid_rst_last_mem", last_grant_mem, 0);
      rst = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
      mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'hAA;
      settle();
      check("post_rst_alu_ready", alu_ready, 1);
      check("post_rst_mem_ready", mem_ready, 0);
      tick();
      alu_valid = 1'b0; mem_valid = 1'b0;
      check("post_rst_addr", rd_addr, 9);
      tick();
      check("post_rst_idle", rd_wr_en, 0);

      // Back-to-back ALU stream
      alu_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         alu_addr = 5'(i);
         alu_data = 32'(i * 32'h100);
         tick();
         check("stream_wr_en", rd_wr_en, 1);
         check("stream_addr", rd_addr, 64'(i));
         check("stream_data", rd_data, 64'(i * 32'h100));
      end
      alu_valid = 1'b0;
      tick();
      check("stream_end_wr_en", rd_wr_en, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
